// File: rtl/utlb_pkg.sv
// Shared types for the micro-TLB: translated entry layout, FSM states and helpers.
package utlb_pkg;

    localparam int M_WIDTH  = 32;
    localparam int LG_PG_SZ = 12;
    localparam int VPN_W    = M_WIDTH - LG_PG_SZ;

    typedef struct packed {
        logic             valid;
        logic             bogus;
        logic             readable;
        logic             writable;
        logic             executable;
        logic             user;
        logic [VPN_W-1:0] paddr;
    } utlb_entry_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        REPLAY    = 2'd3
    } utlb_state_t;

    // An entry can be used for translation only if the tlb marked it valid and not bogus.
    function automatic logic entry_usable(input utlb_entry_t e);
        return e.valid & ~e.bogus;
    endfunction

endpackage

// File: rtl/utlb_cam.sv
// Fully-associative tag/entry store with a single parallel-compare lookup port and one write port.
module utlb_cam
    import utlb_pkg::*;
#(
    parameter int N_ENTRIES = 8,
    parameter int LG_N      = $clog2(N_ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [VPN_W-1:0]  lookup_vpn_i,
    output logic              match_o,
    output logic [LG_N-1:0]   match_idx_o,
    output utlb_entry_t       match_entry_o,
    input  logic              wr_en_i,
    input  logic [LG_N-1:0]   wr_idx_i,
    input  logic [VPN_W-1:0]  wr_tag_i,
    input  utlb_entry_t       wr_entry_i,
    input  logic              clear_all_i
);

    logic [N_ENTRIES-1:0] valid_q;
    logic [VPN_W-1:0]     tag_q   [N_ENTRIES];
    utlb_entry_t          entry_q [N_ENTRIES];
    logic [N_ENTRIES-1:0] hit_vec;

    // Valid bits: cleared by reset or clear_all (which beats a same-cycle write), set on write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (clear_all_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and payload storage needs no reset because valid bits qualify every use.
    always_ff @(posedge clk) begin
        if (wr_en_i && !clear_all_i) begin
            tag_q[wr_idx_i]   <= wr_tag_i;
            entry_q[wr_idx_i] <= wr_entry_i;
        end
    end

    // Parallel compare; fills never create duplicates, so hit_vec is at most one-hot.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            hit_vec[i] = valid_q[i] && (tag_q[i] == lookup_vpn_i);
        end
    end

    // One-hot to index and OR-mux of the matching payload.
    always_comb begin
        match_idx_o   = '0;
        match_entry_o = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (hit_vec[i]) begin
                match_idx_o   = match_idx_o | LG_N'(i);
                match_entry_o = match_entry_o | entry_q[i];
            end
        end
    end

    assign match_o = |hit_vec;

endmodule

// File: rtl/utlb.sv
// Per-side micro-TLB: answers hits one cycle after a request and refills misses from the shared tlb.
module utlb
    import utlb_pkg::*;
#(
    parameter int N_ENTRIES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req,
    input  logic [VPN_W-1:0]  req_vpn,
    output logic              ready,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic              rsp_fault,
    output logic              rsp_refilled,
    output utlb_entry_t       rsp_entry,
    output logic              tlb_req,
    output logic [VPN_W-1:0]  tlb_vpn,
    input  logic              tlb_rsp_valid,
    input  utlb_entry_t       tlb_rsp
);

    localparam int LG_N = $clog2(N_ENTRIES);

    utlb_state_t      state_q;
    logic [LG_N-1:0]  repl_q;
    logic [VPN_W-1:0] tlb_vpn_q;
    logic             ready_q;
    logic             rsp_valid_q;
    logic             rsp_hit_q;
    logic             rsp_fault_q;
    logic             rsp_refilled_q;
    utlb_entry_t      rsp_entry_q;
    logic             tlb_req_q;
    logic             drop_fill_q;

    logic             cam_match;
    logic [LG_N-1:0]  cam_idx;
    utlb_entry_t      cam_entry;
    logic [VPN_W-1:0] lookup_vpn;
    logic             fill_en;
    logic [LG_N-1:0]  fill_idx;

    // In IDLE the array answers the incoming request; during a miss it is probed with the
    // outstanding vpn so a fill reuses an existing slot instead of creating a duplicate.
    assign lookup_vpn = (state_q == IDLE) ? req_vpn : tlb_vpn_q;

    // A usable tlb answer is installed unless a flush arrived during this miss or right now.
    assign fill_en  = (state_q == MISS_WAIT) && tlb_rsp_valid && entry_usable(tlb_rsp)
                      && !flush && !drop_fill_q;
    assign fill_idx = cam_match ? cam_idx : repl_q;

    utlb_cam #(
        .N_ENTRIES (N_ENTRIES),
        .LG_N      (LG_N)
    ) u_cam (
        .clk           (clk),
        .reset         (reset),
        .lookup_vpn_i  (lookup_vpn),
        .match_o       (cam_match),
        .match_idx_o   (cam_idx),
        .match_entry_o (cam_entry),
        .wr_en_i       (fill_en),
        .wr_idx_i      (fill_idx),
        .wr_tag_i      (tlb_vpn_q),
        .wr_entry_i    (tlb_rsp),
        .clear_all_i   (flush)
    );

    // Miss FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            repl_q         <= '0;
            tlb_vpn_q      <= '0;
            ready_q        <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_hit_q      <= 1'b0;
            rsp_fault_q    <= 1'b0;
            rsp_refilled_q <= 1'b0;
            rsp_entry_q    <= '0;
            tlb_req_q      <= 1'b0;
            drop_fill_q    <= 1'b0;
        end else begin
            rsp_valid_q    <= 1'b0;
            rsp_hit_q      <= 1'b0;
            rsp_fault_q    <= 1'b0;
            rsp_refilled_q <= 1'b0;
            tlb_req_q      <= 1'b0;

            if (fill_en && !cam_match) begin
                repl_q <= repl_q + LG_N'(1);
            end

            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (cam_match) begin
                            rsp_valid_q <= 1'b1;
                            rsp_hit_q   <= 1'b1;
                            rsp_entry_q <= cam_entry;
                        end else begin
                            tlb_vpn_q   <= req_vpn;
                            tlb_req_q   <= 1'b1;
                            ready_q     <= 1'b0;
                            drop_fill_q <= 1'b0;
                            state_q     <= MISS_REQ;
                        end
                    end
                end
                MISS_REQ: begin
                    if (flush) begin
                        drop_fill_q <= 1'b1;
                    end
                    state_q <= MISS_WAIT;
                end
                MISS_WAIT: begin
                    if (flush) begin
                        drop_fill_q <= 1'b1;
                    end
                    if (tlb_rsp_valid) begin
                        rsp_valid_q    <= 1'b1;
                        rsp_refilled_q <= 1'b1;
                        rsp_hit_q      <= entry_usable(tlb_rsp);
                        rsp_fault_q    <= ~entry_usable(tlb_rsp);
                        rsp_entry_q    <= tlb_rsp;
                        state_q        <= REPLAY;
                    end
                end
                REPLAY: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready        = ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_hit      = rsp_hit_q;
    assign rsp_fault    = rsp_fault_q;
    assign rsp_refilled = rsp_refilled_q;
    assign rsp_entry    = rsp_entry_q;
    assign tlb_req      = tlb_req_q;
    assign tlb_vpn      = tlb_vpn_q;

endmodule

// File: tb/tb_utlb.sv
// Randomized bench for utlb with a behavioural model of the entry array and a scripted tlb.
module tb_utlb;
    import utlb_pkg::*;

    localparam int N = 8;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             req;
    logic [VPN_W-1:0] req_vpn;
    logic             ready;
    logic             rsp_valid;
    logic             rsp_hit;
    logic             rsp_fault;
    logic             rsp_refilled;
    utlb_entry_t      rsp_entry;
    logic             tlb_req;
    logic [VPN_W-1:0] tlb_vpn;
    logic             tlb_rsp_valid;
    utlb_entry_t      tlb_rsp;

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model: what the cache should hold, as a list of (tag, entry) slots.
    logic [VPN_W-1:0] mTag   [N];
    bit               mValid [N];
    utlb_entry_t      mEntry [N];
    int               mRepl;

    logic [VPN_W-1:0] pool [12];

    utlb #(.N_ENTRIES(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .req           (req),
        .req_vpn       (req_vpn),
        .ready         (ready),
        .rsp_valid     (rsp_valid),
        .rsp_hit       (rsp_hit),
        .rsp_fault     (rsp_fault),
        .rsp_refilled  (rsp_refilled),
        .rsp_entry     (rsp_entry),
        .tlb_req       (tlb_req),
        .tlb_vpn       (tlb_vpn),
        .tlb_rsp_valid (tlb_rsp_valid),
        .tlb_rsp       (tlb_rsp)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int modelFind(input logic [VPN_W-1:0] vpn);
        for (int i = 0; i < N; i++) begin
            if (mValid[i] && mTag[i] == vpn) return i;
        end
        return -1;
    endfunction

    function automatic void modelFlush();
        for (int i = 0; i < N; i++) mValid[i] = 0;
    endfunction

    function automatic void modelInstall(input logic [VPN_W-1:0] vpn, input utlb_entry_t e);
        int slot;
        slot = modelFind(vpn);
        if (slot < 0) begin
            slot  = mRepl;
            mRepl = (mRepl + 1) % N;
        end
        mTag[slot]   = vpn;
        mEntry[slot] = e;
        mValid[slot] = 1;
    endfunction

    // mode 0: good translation, 1: bogus, 2: invalid.
    function automatic utlb_entry_t makeTlbEntry(input logic [VPN_W-1:0] vpn, input int mode);
        utlb_entry_t e;
        e.valid      = (mode != 2);
        e.bogus      = (mode == 1);
        e.readable   = 1'b1;
        e.writable   = vpn[0];
        e.executable = vpn[1];
        e.user       = vpn[2];
        e.paddr      = vpn;
        return e;
    endfunction

    task automatic applyReset();
        reset         = 1'b0;
        flush         = 1'b0;
        req           = 1'b0;
        req_vpn       = '0;
        tlb_rsp_valid = 1'b0;
        tlb_rsp       = '0;
        modelFlush();
        mRepl = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One request from IDLE to completion, checked cycle by cycle against the model.
    task automatic applyStimulus(input logic [VPN_W-1:0] vpn, input int mode,
                                 input bit flushInWait, input bit flushWithReq);
        int          idx;
        bit          expHit;
        bit          usable;
        utlb_entry_t tlbE;
        idx    = modelFind(vpn);
        expHit = (idx >= 0);
        @(negedge clk);
        checkOutput("ready_idle", ready, 1);
        req     = 1'b1;
        req_vpn = vpn;
        flush   = flushWithReq && expHit;
        @(negedge clk);
        req   = 1'b0;
        flush = 1'b0;
        if (expHit) begin
            checkOutput("hit_valid", rsp_valid, 1);
            checkOutput("hit_hit", rsp_hit, 1);
            checkOutput("hit_fault", rsp_fault, 0);
            checkOutput("hit_refilled", rsp_refilled, 0);
            checkOutput("hit_entry", rsp_entry, mEntry[idx]);
            checkOutput("hit_no_tlb_req", tlb_req, 0);
            checkOutput("hit_ready", ready, 1);
            if (flushWithReq) modelFlush();
        end else begin
            checkOutput("miss_no_rsp", rsp_valid, 0);
            checkOutput("miss_tlb_req", tlb_req, 1);
            checkOutput("miss_tlb_vpn", tlb_vpn, vpn);
            checkOutput("miss_not_ready", ready, 0);
            @(negedge clk);
            checkOutput("wait_tlb_req_low", tlb_req, 0);
            checkOutput("wait_tlb_vpn", tlb_vpn, vpn);
            checkOutput("wait_no_rsp", rsp_valid, 0);
            flush = flushInWait;
            @(negedge clk);
            flush = 1'b0;
            checkOutput("wait2_no_rsp", rsp_valid, 0);
            checkOutput("wait2_tlb_vpn", tlb_vpn, vpn);
            tlbE          = makeTlbEntry(vpn, mode);
            tlb_rsp_valid = 1'b1;
            tlb_rsp       = tlbE;
            @(negedge clk);
            tlb_rsp_valid = 1'b0;
            tlb_rsp       = utlb_entry_t'($urandom);
            usable = tlbE.valid && !tlbE.bogus;
            checkOutput("replay_valid", rsp_valid, 1);
            checkOutput("replay_refilled", rsp_refilled, 1);
            checkOutput("replay_hit", rsp_hit, usable);
            checkOutput("replay_fault", rsp_fault, !usable);
            checkOutput("replay_entry", rsp_entry, tlbE);
            checkOutput("replay_not_ready", ready, 0);
            checkOutput("replay_tlb_req_low", tlb_req, 0);
            if (flushInWait) modelFlush();
            else if (usable) modelInstall(vpn, tlbE);
            @(negedge clk);
            checkOutput("post_no_rsp", rsp_valid, 0);
            checkOutput("post_hit_low", rsp_hit, 0);
            checkOutput("post_fault_low", rsp_fault, 0);
            checkOutput("post_refilled_low", rsp_refilled, 0);
            checkOutput("post_ready", ready, 1);
        end
    endtask

    // Back-to-back requests to resident vpns; each answered on the following cycle.
    task automatic applyBurst(input int n);
        logic [VPN_W-1:0] resident [$];
        logic [VPN_W-1:0] prev;
        for (int i = 0; i < N; i++) if (mValid[i]) resident.push_back(mTag[i]);
        if (resident.size() == 0) return;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checkOutput("burst_valid", rsp_valid, 1);
                checkOutput("burst_hit", rsp_hit, 1);
                checkOutput("burst_entry", rsp_entry, mEntry[modelFind(prev)]);
                checkOutput("burst_no_tlb_req", tlb_req, 0);
            end
            if (k < n) begin
                prev    = resident[$urandom_range(0, resident.size() - 1)];
                req     = 1'b1;
                req_vpn = prev;
            end else begin
                req = 1'b0;
            end
        end
    endtask

    // Reset asserted while waiting on the tlb, followed by a stray tlb response.
    task automatic applyResetMidMiss(input logic [VPN_W-1:0] vpn);
        @(negedge clk);
        req     = 1'b1;
        req_vpn = vpn;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_tlb_req", tlb_req, 0);
        checkOutput("rst_tlb_vpn", tlb_vpn, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_entry", rsp_entry, 0);
        modelFlush();
        mRepl = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tlb_rsp_valid = 1'b1;
        tlb_rsp       = makeTlbEntry(vpn, 0);
        @(negedge clk);
        tlb_rsp_valid = 1'b0;
        checkOutput("stray_no_rsp", rsp_valid, 0);
        checkOutput("stray_ready", ready, 1);
        @(negedge clk);
        checkOutput("stray_no_rsp2", rsp_valid, 0);
    endtask

    initial begin
        logic [VPN_W-1:0] v;
        int               mode;
        int               r;
        applyReset();

        // Values held in reset, sampled after release before any request.
        checkOutput("reset_ready", ready, 1);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_tlb_req", tlb_req, 0);
        checkOutput("reset_tlb_vpn", tlb_vpn, 0);
        checkOutput("reset_rsp_entry", rsp_entry, 0);

        // Cold miss then hits, including back-to-back.
        applyStimulus(20'h12345, 0, 0, 0);
        applyStimulus(20'h12345, 0, 0, 0);
        applyBurst(4);

        // Replacement: nine distinct vpns into eight slots evict the first.
        applyReset();
        for (int k = 0; k < 9; k++) applyStimulus(VPN_W'(20'h30000 + k * 20'h111), 0, 0, 0);
        for (int k = 1; k < 9; k++) applyStimulus(VPN_W'(20'h30000 + k * 20'h111), 0, 0, 0);
        applyStimulus(20'h30000, 0, 0, 0);

        // Faults: bogus and invalid answers are reported and not cached.
        applyStimulus(20'h0ABCD, 1, 0, 0);
        applyStimulus(20'h0ABCD, 2, 0, 0);
        applyStimulus(20'h0ABCD, 0, 0, 0);

        // Flush during MISS_WAIT: replay still hits, nothing survives.
        applyStimulus(20'h55555, 0, 1, 0);
        applyStimulus(20'h55555, 0, 0, 0);
        applyStimulus(20'h30111, 0, 0, 0);

        // Flush together with a hitting request: hit still reported, then gone.
        applyStimulus(20'h30111, 0, 0, 1);
        applyStimulus(20'h30111, 0, 0, 0);

        // Reset in the middle of a miss.
        applyResetMidMiss(20'h77777);
        applyStimulus(20'h77777, 0, 0, 0);

        // Randomized traffic over a pool larger than the cache.
        for (int i = 0; i < 12; i++) pool[i] = VPN_W'(($urandom & 32'hFFFF0) | i);
        for (int it = 0; it < 80; it++) begin
            v    = pool[$urandom_range(0, 11)];
            r    = $urandom_range(0, 19);
            mode = (r < 2) ? 1 : (r < 3) ? 2 : 0;
            applyStimulus(v, mode, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
            if ($urandom_range(0, 7) == 0) applyBurst($urandom_range(1, 4));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
